// File: rtl/async_fifo_fwft_if.sv
// +------------------------------------------------------------------+
// | async_fifo_fwft_if : write/read handshake bundle of the dual-clock FIFO |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface async_fifo_fwft_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [ADDR_WIDTH:0]   afull_thresh;
  logic                  full;
  logic                  afull;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;
  logic                  ovf_clr;
  logic                  rd_en;
  logic [ADDR_WIDTH:0]   aempty_thresh;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  aempty;
  logic [ADDR_WIDTH:0]   rd_level;
  logic                  underflow;
  logic                  unf_clr;

  modport master (
    output wr_en, wr_data, afull_thresh, ovf_clr, rd_en, aempty_thresh, unf_clr,
    input  full, afull, wr_level, overflow, rd_data, rd_valid, empty, aempty,
           rd_level, underflow
  );

  modport slave (
    input  wr_en, wr_data, afull_thresh, ovf_clr, rd_en, aempty_thresh, unf_clr,
    output full, afull, wr_level, overflow, rd_data, rd_valid, empty, aempty,
           rd_level, underflow
  );
endinterface

`default_nettype wire

// File: rtl/async_fifo_fwft.sv
// +------------------------------------------------------------------+
// | async_fifo_fwft : dual-clock gray-pointer FIFO, FWFT or standard read |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module async_fifo_fwft #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FWFT        = 1
) (
  input  wire logic        wr_clk,
  input  wire logic        wr_rst_n,
  input  wire logic        rd_clk,
  input  wire logic        rd_rst_n,
  async_fifo_fwft_if.slave fifo_if
);
  localparam int c_PTR_W = ADDR_WIDTH + 1;
  localparam int c_DEPTH = 1 << ADDR_WIDTH;

  function automatic logic [c_PTR_W-1:0] bin2gray(input logic [c_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [c_PTR_W-1:0] gray2bin(input logic [c_PTR_W-1:0] g);
    logic [c_PTR_W-1:0] b;
    b[c_PTR_W-1] = g[c_PTR_W-1];
    for (int i = c_PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];

  // ---------------- write domain ----------------
  logic [c_PTR_W-1:0] r_wr_bin, r_wr_gray, r_wr_level;
  logic [c_PTR_W-1:0] r_rd_gray_sync [SYNC_STAGES];
  logic [c_PTR_W-1:0] w_wr_bin_nxt, w_wr_gray_nxt, w_rd_bin_sync, w_rd_gray_last, w_wr_level_nxt;
  logic               r_full, r_afull, r_ovf;
  logic               w_wr_vld, w_full_nxt;

  assign w_wr_vld       = fifo_if.wr_en & ~r_full;
  assign w_wr_bin_nxt   = r_wr_bin + c_PTR_W'(w_wr_vld);
  assign w_wr_gray_nxt  = bin2gray(w_wr_bin_nxt);
  assign w_rd_gray_last = r_rd_gray_sync[SYNC_STAGES-1];
  assign w_rd_bin_sync  = gray2bin(w_rd_gray_last);
  assign w_wr_level_nxt = w_wr_bin_nxt - w_rd_bin_sync;
  // Full when the write pointer is one lap ahead: top two gray bits inverted.
  assign w_full_nxt     = (w_wr_gray_nxt ==
                           {~w_rd_gray_last[c_PTR_W-1 -: 2], w_rd_gray_last[c_PTR_W-3:0]});

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      r_wr_bin   <= '0;
      r_wr_gray  <= '0;
      r_wr_level <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_ovf      <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_rd_gray_sync[i] <= '0;
    end else begin
      r_rd_gray_sync[0] <= r_rd_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_rd_gray_sync[i] <= r_rd_gray_sync[i-1];
      r_wr_bin   <= w_wr_bin_nxt;
      r_wr_gray  <= w_wr_gray_nxt;
      r_wr_level <= w_wr_level_nxt;
      r_full     <= w_full_nxt;
      r_afull    <= (w_wr_level_nxt >= fifo_if.afull_thresh);
      if (fifo_if.ovf_clr)
        r_ovf <= 1'b0;
      else if (fifo_if.wr_en && r_full)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (w_wr_vld) r_mem[r_wr_bin[ADDR_WIDTH-1:0]] <= fifo_if.wr_data;
  end

  // ---------------- read domain ----------------
  logic [c_PTR_W-1:0]    r_rd_bin, r_rd_gray, r_rd_level;
  logic [c_PTR_W-1:0]    r_wr_gray_sync [SYNC_STAGES];
  logic [c_PTR_W-1:0]    w_rd_bin_nxt, w_wr_bin_sync, w_cons_nxt, w_rd_level_nxt;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_ram_empty, r_vld, r_aempty, r_unf;
  logic                  w_rd_inc, w_vld_nxt, w_unf_req, w_empty, w_ram_empty_nxt;

  generate
    if (FWFT != 0) begin : g_fwft
      logic w_pop;
      assign w_pop      = fifo_if.rd_en & r_vld;
      assign w_rd_inc   = (~r_vld | w_pop) & ~r_ram_empty;
      assign w_vld_nxt  = w_rd_inc | (r_vld & ~w_pop);
      assign w_unf_req  = fifo_if.rd_en & ~r_vld;
      assign w_empty    = ~r_vld;
      // The prefetched word is still owned by the FIFO until popped, so the
      // pointer seen by the writer lags the RAM fetch pointer by the register.
      assign w_cons_nxt = w_rd_bin_nxt - c_PTR_W'(w_vld_nxt);
    end else begin : g_std
      assign w_rd_inc   = fifo_if.rd_en & ~r_ram_empty;
      assign w_vld_nxt  = w_rd_inc;
      assign w_unf_req  = fifo_if.rd_en & r_ram_empty;
      assign w_empty    = r_ram_empty;
      assign w_cons_nxt = w_rd_bin_nxt;
    end
  endgenerate

  assign w_rd_bin_nxt    = r_rd_bin + c_PTR_W'(w_rd_inc);
  assign w_wr_bin_sync   = gray2bin(r_wr_gray_sync[SYNC_STAGES-1]);
  assign w_ram_empty_nxt = (bin2gray(w_rd_bin_nxt) == r_wr_gray_sync[SYNC_STAGES-1]);
  assign w_rd_level_nxt  = w_wr_bin_sync - w_cons_nxt;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_rd_bin    <= '0;
      r_rd_gray   <= '0;
      r_rd_level  <= '0;
      r_rd_data   <= '0;
      r_ram_empty <= 1'b1;
      r_vld       <= 1'b0;
      r_aempty    <= 1'b1;
      r_unf       <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) r_wr_gray_sync[i] <= '0;
    end else begin
      r_wr_gray_sync[0] <= r_wr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) r_wr_gray_sync[i] <= r_wr_gray_sync[i-1];
      r_rd_bin    <= w_rd_bin_nxt;
      r_rd_gray   <= bin2gray(w_cons_nxt);
      r_ram_empty <= w_ram_empty_nxt;
      r_vld       <= w_vld_nxt;
      r_rd_level  <= w_rd_level_nxt;
      r_aempty    <= (w_rd_level_nxt <= fifo_if.aempty_thresh);
      if (w_rd_inc) r_rd_data <= r_mem[r_rd_bin[ADDR_WIDTH-1:0]];
      if (fifo_if.unf_clr)
        r_unf <= 1'b0;
      else if (w_unf_req)
        r_unf <= 1'b1;
    end
  end

  assign fifo_if.full      = r_full;
  assign fifo_if.afull     = r_afull;
  assign fifo_if.wr_level  = r_wr_level;
  assign fifo_if.overflow  = r_ovf;
  assign fifo_if.rd_data   = r_rd_data;
  assign fifo_if.rd_valid  = r_vld;
  assign fifo_if.empty     = w_empty;
  assign fifo_if.aempty    = r_aempty;
  assign fifo_if.rd_level  = r_rd_level;
  assign fifo_if.underflow = r_unf;
endmodule

`default_nettype wire

// File: tb/tb_async_fifo_fwft.sv
// +------------------------------------------------------------------+
// | tb_async_fifo_fwft : directed checks of FWFT and standard-mode FIFOs |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module tb_async_fifo_fwft;
  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rst_n = 1'b0;
  logic rd_rst_n = 1'b0;
  real  rd_half = 13.5;
  int   n_cmp = 0;
  int   n_err = 0;

  async_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) fa ();
  async_fifo_fwft_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) fb ();

  async_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2), .FWFT(1)) u_fwft (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_if(fa)
  );
  async_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .SYNC_STAGES(2), .FWFT(0)) u_std (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .fifo_if(fb)
  );

  always #5 wr_clk = ~wr_clk;
  initial forever #(rd_half) rd_clk = ~rd_clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge wr_clk);
    fa.wr_en = 1'b1;
    fa.wr_data = d;
    @(negedge wr_clk);
    fa.wr_en = 1'b0;
  endtask

  task automatic pop_a(input logic [7:0] exp);
    int n = 0;
    @(negedge rd_clk);
    while (!fa.rd_valid && n < 20) begin
      @(negedge rd_clk);
      n++;
    end
    chk("pop_valid", fa.rd_valid, 1);
    chk("pop_data", fa.rd_data, exp);
    fa.rd_en = 1'b1;
    @(negedge rd_clk);
    fa.rd_en = 1'b0;
  endtask

  task automatic chk_reset_a();
    chk("rst_full", fa.full, 0);
    chk("rst_afull", fa.afull, 0);
    chk("rst_wr_level", fa.wr_level, 0);
    chk("rst_overflow", fa.overflow, 0);
    chk("rst_empty", fa.empty, 1);
    chk("rst_aempty", fa.aempty, 1);
    chk("rst_rd_valid", fa.rd_valid, 0);
    chk("rst_rd_data", fa.rd_data, 0);
    chk("rst_rd_level", fa.rd_level, 0);
    chk("rst_underflow", fa.underflow, 0);
  endtask

  initial begin
    logic [7:0] sb[$];
    logic [7:0] wcnt = 8'h00;
    bit         s_done = 1'b0;
    int         viol = 0;
    int         npop = 0;
    int         n;

    fa.wr_en = 0; fa.wr_data = 0; fa.ovf_clr = 0; fa.rd_en = 0; fa.unf_clr = 0;
    fa.afull_thresh = 5'd16; fa.aempty_thresh = 5'd0;
    fb.wr_en = 0; fb.wr_data = 0; fb.ovf_clr = 0; fb.rd_en = 0; fb.unf_clr = 0;
    fb.afull_thresh = 5'd16; fb.aempty_thresh = 5'd0;

    #120;
    chk_reset_a();
    chk("rst_std_empty", fb.empty, 1);
    chk("rst_std_valid", fb.rd_valid, 0);
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    repeat (4) @(negedge wr_clk);

    // Fill to full, overflow, clear, then drain in order
    for (int i = 0; i < 16; i++) begin
      push_a(8'(i));
      if (i == 14) chk("full_at_15", fa.full, 0);
    end
    chk("full_at_16", fa.full, 1);
    chk("afull_at_16", fa.afull, 1);
    chk("wr_level_16", fa.wr_level, 16);
    chk("ovf_before", fa.overflow, 0);
    push_a(8'hEE);
    chk("ovf_set", fa.overflow, 1);
    chk("wr_level_hold", fa.wr_level, 16);
    @(negedge wr_clk);
    fa.wr_en = 1'b1; fa.ovf_clr = 1'b1;
    @(negedge wr_clk);
    fa.wr_en = 1'b0; fa.ovf_clr = 1'b0;
    chk("ovf_clr_wins", fa.overflow, 0);
    for (int i = 0; i < 16; i++) pop_a(8'(i));
    repeat (3) @(negedge rd_clk);
    chk("drain_empty", fa.empty, 1);
    chk("drain_rd_level", fa.rd_level, 0);
    chk("drain_underflow", fa.underflow, 0);
    repeat (6) @(negedge wr_clk);
    chk("drain_full", fa.full, 0);

    // Single word latency, both read modes
    @(negedge wr_clk);
    fa.wr_en = 1'b1; fa.wr_data = 8'hA5;
    fb.wr_en = 1'b1; fb.wr_data = 8'hA5;
    @(posedge wr_clk);
    #1;
    fa.wr_en = 1'b0; fb.wr_en = 1'b0;
    n = 0;
    while (!fa.rd_valid && n < 10) begin
      @(posedge rd_clk);
      #1;
      n++;
    end
    chk("fwft_latency_ok", (n <= 4), 1);
    chk("fwft_data", fa.rd_data, 8'hA5);
    @(negedge rd_clk);
    fa.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    fa.rd_en = 1'b0;
    chk("fwft_pop_empty", fa.empty, 1);
    chk("fwft_pop_valid", fa.rd_valid, 0);
    @(negedge rd_clk);
    fa.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    fa.rd_en = 1'b0;
    chk("fwft_underflow", fa.underflow, 1);
    @(negedge rd_clk);
    fa.unf_clr = 1'b1;
    @(posedge rd_clk);
    #1;
    fa.unf_clr = 1'b0;
    chk("fwft_unf_clr", fa.underflow, 0);

    chk("std_not_empty", fb.empty, 0);
    chk("std_no_valid", fb.rd_valid, 0);
    @(negedge rd_clk);
    fb.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    fb.rd_en = 1'b0;
    chk("std_valid", fb.rd_valid, 1);
    chk("std_data", fb.rd_data, 8'hA5);
    chk("std_empty", fb.empty, 1);
    @(posedge rd_clk);
    #1;
    chk("std_valid_pulse", fb.rd_valid, 0);
    chk("std_data_hold", fb.rd_data, 8'hA5);
    @(negedge rd_clk);
    fb.rd_en = 1'b1;
    @(posedge rd_clk);
    #1;
    fb.rd_en = 1'b0;
    chk("std_underflow", fb.underflow, 1);
    chk("std_unf_data_hold", fb.rd_data, 8'hA5);
    @(negedge rd_clk);
    fb.unf_clr = 1'b1;
    @(posedge rd_clk);
    #1;
    fb.unf_clr = 1'b0;
    chk("std_unf_clr", fb.underflow, 0);

    // Thresholds: afull at 12, aempty at 2
    fa.afull_thresh = 5'd12;
    fa.aempty_thresh = 5'd2;
    repeat (8) @(negedge wr_clk);
    for (int i = 0; i < 11; i++) push_a(8'h40 + 8'(i));
    chk("afull_11", fa.afull, 0);
    chk("wr_level_11", fa.wr_level, 11);
    push_a(8'h4B);
    chk("afull_12", fa.afull, 1);
    chk("wr_level_12", fa.wr_level, 12);
    repeat (8) @(negedge rd_clk);
    chk("rd_level_12", fa.rd_level, 12);
    chk("aempty_12", fa.aempty, 0);
    for (int i = 0; i < 9; i++) pop_a(8'h40 + 8'(i));
    chk("rd_level_3", fa.rd_level, 3);
    chk("aempty_3", fa.aempty, 0);
    pop_a(8'h49);
    chk("rd_level_2", fa.rd_level, 2);
    chk("aempty_2", fa.aempty, 1);
    pop_a(8'h4A);
    pop_a(8'h4B);

    // Steady streaming around eight entries with varying clock ratio
    fa.afull_thresh = 5'd16;
    fa.aempty_thresh = 5'd0;
    repeat (8) @(negedge wr_clk);
    for (int i = 0; i < 8; i++) begin
      push_a(wcnt);
      sb.push_back(wcnt);
      wcnt++;
    end
    repeat (8) @(negedge rd_clk);
    fork
      begin
        for (int c = 0; c < 1000; c++) begin
          @(negedge wr_clk);
          if (c % 250 == 0) rd_half = real'($urandom_range(2, 15)) + 0.25;
          if (fa.wr_level < 8 || fa.wr_level > 11) viol++;
          if (fa.wr_level <= 10) begin
            fa.wr_en = 1'b1;
            fa.wr_data = wcnt;
            sb.push_back(wcnt);
            wcnt++;
          end else begin
            fa.wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        fa.wr_en = 1'b0;
        s_done = 1'b1;
      end
      begin
        do begin
          @(negedge rd_clk);
          if (!s_done && fa.rd_valid && fa.rd_level >= 9 && sb.size() > 0) begin
            chk("stream_data", fa.rd_data, sb.pop_front());
            npop++;
            fa.rd_en = 1'b1;
          end else begin
            fa.rd_en = 1'b0;
          end
        end while (!s_done);
      end
    join
    rd_half = 13.5;
    chk("stream_level_range", viol, 0);
    chk("stream_progress", (npop > 100), 1);
    while (sb.size() > 0) pop_a(sb.pop_front());
    chk("stream_overflow", fa.overflow, 0);
    chk("stream_underflow", fa.underflow, 0);

    // Reset mid-stream at half full, then a fresh full cycle
    repeat (6) @(negedge wr_clk);
    for (int i = 0; i < 8; i++) push_a(8'h21 + 8'(i));
    repeat (8) @(negedge rd_clk);
    chk("pre_rst_valid", fa.rd_valid, 1);
    @(negedge wr_clk);
    wr_rst_n = 1'b0;
    rd_rst_n = 1'b0;
    #1;
    chk_reset_a();
    #150;
    wr_rst_n = 1'b1;
    rd_rst_n = 1'b1;
    repeat (6) @(negedge wr_clk);
    for (int i = 0; i < 16; i++) push_a(8'h80 + 8'(i));
    chk("post_rst_full", fa.full, 1);
    for (int i = 0; i < 16; i++) pop_a(8'h80 + 8'(i));
    repeat (3) @(negedge rd_clk);
    chk("post_rst_empty", fa.empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/async_fifo_fwft.md
Name: async_fifo_fwft

Overview:
Parametrised dual-clock FIFO that succeeds the fixed-size async FIFO. It adds the following over that block:
- first-word-fall-through (FWFT) or standard read mode
- configurable synchroniser depth
- run-time almost-full/almost-empty thresholds
- fill-level outputs in both domains
- sticky overflow/underflow error flags

It sits at clock-domain crossings between producer (wr_clk) and consumer (rd_clk) datapaths.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
SYNC_STAGES, 2, flop stages in each gray-pointer synchroniser (legal 2..4)
FWFT, 1, 1 = head word presented on rd_data without rd_en; 0 = standard mode, data one cycle after rd_en

Ports:
wr_clk  in  1  write clock
wr_rst_n  in  1  write-domain reset, asynchronous, active-low
rd_clk  in  1  read clock
rd_rst_n  in  1  read-domain reset, asynchronous, active-low
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
afull_thresh  in  ADDR_WIDTH+1  afull asserts when wr_level >= value
full  out  1  FIFO full (wr domain)
afull  out  1  almost full (wr domain)
wr_level  out  ADDR_WIDTH+1  occupancy seen by the write side
overflow  out  1  sticky: write attempted while full
ovf_clr  in  1  clears overflow (wr domain)
rd_en  in  1  read request / pop
aempty_thresh  in  ADDR_WIDTH+1  aempty asserts when rd_level <= value
rd_data  out  DATA_WIDTH  read data
rd_valid  out  1  rd_data holds a valid word
empty  out  1  FIFO empty (rd domain)
aempty  out  1  almost empty (rd domain)
rd_level  out  ADDR_WIDTH+1  occupancy seen by the read side
underflow  out  1  sticky: read attempted while empty
unf_clr  in  1  clears underflow (rd domain)

Behaviour:
Pointers and flags
- Pointers are ADDR_WIDTH+1 bits: binary for RAM addressing, gray for crossing.
- Gray = bin ^ (bin >> 1), registered before crossing.
- Each pointer is synchronised through SYNC_STAGES flops into the other domain, then converted gray-to-binary.
- wr_vld = wr_en & ~full. RAM write and pointer increment occur on that wr_clk edge.
- Write with full = 1: dropped, no pointer change, overflow set next cycle.
- full is registered from next-pointer compare: wr_gray_nxt == {~rd_gray_sync[MSB:MSB-1], rd_gray_sync[MSB-2:0]}.
- full asserts the cycle after the write that fills the 2**ADDR_WIDTH-th entry.
- empty is registered: rd_gray_nxt == wr_gray_sync.

Occupancy and thresholds
- wr_level = wr_bin_nxt - rd_bin_sync (registered, mod 2**(ADDR_WIDTH+1)).
- rd_level = wr_bin_sync - rd_bin_nxt (registered).
- afull = wr_level >= afull_thresh; aempty = rd_level <= aempty_thresh. Both are registered and updated with the levels.
- Levels are pessimistic: wr_level may over-report and rd_level may under-report by up to SYNC_STAGES+1 cycles of the other side's traffic, never the reverse.

FWFT = 1
- A one-entry output register is prefetched from RAM whenever it is empty and the RAM is non-empty.
- rd_valid = output register occupied.
- empty = ~rd_valid.
- Pop = rd_en & rd_valid. The next word is loaded on the same edge if available, so back-to-back pops sustain one word per cycle.
- rd_level includes the output register.

FWFT = 0
- rd_vld = rd_en & ~empty.
- rd_data registered; it is valid and rd_valid = 1 in the cycle after rd_vld.
- rd_data holds its value otherwise.

Latency
- First write to empty FIFO clears empty after SYNC_STAGES+1 rd_clk edges (FWFT: +1 for prefetch).
- Read freeing full clears full after SYNC_STAGES+1 wr_clk edges.

Errors
- Read with nothing to pop sets underflow; no pointer change.
- overflow/underflow stay set until the matching clr or reset. Clr wins over a simultaneous set.
- Simultaneous read and write at any fill: both complete; the level is unchanged in steady state.

Reset
- Write domain (wr_rst_n low): full = 0, afull = 0, wr_level = 0, overflow = 0; write pointers and read-pointer synchroniser = 0.
- Read domain (rd_rst_n low): empty = 1, aempty = 1, rd_valid = 0, rd_data = 0, rd_level = 0, underflow = 0; read pointers and write-pointer synchroniser = 0.
- Both resets must overlap by at least SYNC_STAGES+1 cycles of the slower clock. A single-side reset mid-operation is unsupported; the FIFO contents after it are undefined, but flags still reset to the values above.
- RAM contents are not reset.

Test Plan:
- DATA_WIDTH 8, ADDR_WIDTH 4, FWFT 1, wr 100 MHz / rd 37 MHz. Write 0x00..0x0F with rd_en = 0 -> full = 1 after 16th write. Next write sets overflow. Then read 16 words -> data 0x00..0x0F in order, empty = 1.
- FWFT 1, single write 0xA5 into empty FIFO -> rd_valid = 1 with rd_data = 0xA5 within SYNC_STAGES+2 rd_clk cycles, no rd_en required. Pop -> empty = 1 next cycle.
- FWFT 0, same write -> rd_data = 0xA5 one cycle after rd_en, rd_valid pulses one cycle. rd_en while empty sets underflow; unf_clr clears it.
- afull_thresh = 12, aempty_thresh = 2. Fill to 12 -> afull = 1, wr_level = 12. Drain to 2 -> aempty = 1, rd_level = 2.
- Continuous simultaneous rd/wr at 8 entries for 1000 cycles, random clock ratios 1:3 to 3:1 -> no data loss or reorder (scoreboard), overflow = underflow = 0, wr_level within [8, 8+SYNC_STAGES+1].
- Assert both resets mid-stream at half full -> all outputs take the reset values above. After release, FIFO accepts 16 fresh words correctly.
